// File: rtl/reg_bus_arbiter.sv
// Two-requester register-bus arbiter: round-robin grant, one-cycle strobe, one-cycle ack.
// Optional 16-bit pair lock enabled by defining REG_ARB_LOCK16_EN.
module reg_bus_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_wr,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_wr,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic       bus_read,
    output logic       bus_write,
    output logic [5:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       lock_active
);

    if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255) begin : g_bad_timeout
        $error("LOCK_TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic       ptr;
    logic       win;
    logic       cmd_wr;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       elig_a;
    logic       elig_b;
    logic       grant_a;
    logic       grant_b;
    logic       grant_any;
    logic       sel_wr;
    logic [5:0] sel_addr;
    logic [7:0] sel_wdata;

`ifdef REG_ARB_LOCK16_EN
    localparam logic [7:0] CNT_LAST = 8'(LOCK_TIMEOUT - 1);

    logic       lock_q;
    logic       lock_owner;
    logic [5:0] lock_hi;
    logic [7:0] lock_cnt;
    logic       owner_req;
    logic       lock_hit;

    assign owner_req   = lock_owner ? b_req : a_req;
    assign lock_hit    = sel_wr && (sel_addr == 6'h00 ||
                                    sel_addr == 6'h03 ||
                                    sel_addr == 6'h05);
    assign elig_a      = a_req && (!lock_q || !lock_owner);
    assign elig_b      = b_req && (!lock_q || lock_owner);
    assign lock_active = lock_q;

    // Lock owner tracking: set on a low-half write, cleared by the high half or by idle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_owner <= 1'b0;
            lock_hi    <= '0;
            lock_cnt   <= '0;
        end else if (state == IDLE && grant_any && lock_hit) begin
            lock_q     <= 1'b1;
            lock_owner <= grant_b;
            lock_hi    <= sel_addr + 6'd1;
            lock_cnt   <= '0;
        end else if (state == DONE && lock_q &&
                     win == lock_owner && cmd_addr == lock_hi) begin
            lock_q   <= 1'b0;
            lock_cnt <= '0;
        end else if (state == IDLE && lock_q && !owner_req) begin
            if (lock_cnt == CNT_LAST) begin
                lock_q   <= 1'b0;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    assign elig_a      = a_req;
    assign elig_b      = b_req;
    assign lock_active = 1'b0;
`endif

    // Grant selection: the pointer only breaks ties between two eligible requests
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (elig_a && elig_b) begin
            grant_a = !ptr;
            grant_b = ptr;
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
    end

    assign grant_any = grant_a || grant_b;
    assign sel_wr    = grant_b ? b_wr    : a_wr;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and decoded bus/ack outputs
    always_comb begin
        state_nx  = state;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx  = DONE;
                bus_read  = !cmd_wr;
                bus_write = cmd_wr;
                bus_addr  = cmd_addr;
                bus_wdata = cmd_wdata;
            end
            DONE: begin
                state_nx = IDLE;
                a_ack    = !win;
                b_ack    = win;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Command latch at grant, pointer update, and read-data capture at the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            win       <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                win       <= grant_b;
                ptr       <= !grant_b;
                cmd_wr    <= sel_wr;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
            end
            if (state == ISSUE && !cmd_wr) begin
                if (win) begin
                    b_rdata <= bus_rdata;
                end else begin
                    a_rdata <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: expected bus cycles and acks are queued at drive time.
// Lock scenarios run only when REG_ARB_LOCK16_EN is defined.
module tb_reg_bus_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_wr = 1'b0;
    logic [5:0] a_addr = '0;
    logic [7:0] a_wdata = '0;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req = 1'b0, b_wr = 1'b0;
    logic [5:0] b_addr = '0;
    logic [7:0] b_wdata = '0;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       bus_read, bus_write;
    logic [5:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       busy, lock_active;

    reg_bus_arbiter #(.LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_fn(input logic [5:0] a);
        return (a == 6'h08) ? 8'hC3 : ({a, 2'b01} ^ 8'h40);
    endfunction

    assign bus_rdata = bus_read ? rd_fn(bus_addr) : 8'h00;

    typedef struct packed {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
    } bus_t;

    typedef struct packed {
        logic       is_b;
        logic       wr;
        logic [7:0] rdata;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];
    bus_t mb;
    ack_t ma;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push_tx(input logic is_b, input logic wr,
                           input logic [5:0] addr, input logic [7:0] wdata);
        bus_t eb;
        ack_t ea;
        eb.wr    = wr;
        eb.addr  = addr;
        eb.wdata = wdata;
        ea.is_b  = is_b;
        ea.wr    = wr;
        ea.rdata = wr ? 8'h00 : rd_fn(addr);
        exp_bus.push_back(eb);
        exp_ack.push_back(ea);
    endtask

    task automatic drive_a(input logic wr, input logic [5:0] addr, input logic [7:0] wd);
        a_wr = wr; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    endtask

    task automatic drive_b(input logic wr, input logic [5:0] addr, input logic [7:0] wd);
        b_wr = wr; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    endtask

    // Scoreboard monitor: pops expected bus cycles and acks as the DUT produces them
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (bus_read || bus_write) begin
                if (exp_bus.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_unexpected got rd=%0b wr=%0b addr=%h wdata=%h",
                             bus_read, bus_write, bus_addr, bus_wdata);
                end else begin
                    mb = exp_bus.pop_front();
                    if ({bus_read, bus_write, bus_addr, bus_wdata} !==
                        {!mb.wr, mb.wr, mb.addr, mb.wdata}) begin
                        miscompares++;
                        $display("FAIL bus_cycle got rd=%0b wr=%0b addr=%h wd=%h want wr=%0b addr=%h wd=%h",
                                 bus_read, bus_write, bus_addr, bus_wdata,
                                 mb.wr, mb.addr, mb.wdata);
                    end
                end
            end else if (bus_addr !== 6'h00 || bus_wdata !== 8'h00) begin
                miscompares++;
                $display("FAIL bus_idle got addr=%h wdata=%h want 00/00", bus_addr, bus_wdata);
            end
            if (a_ack || b_ack) begin
                vectors++;
                if (exp_ack.size() == 0) begin
                    miscompares++;
                    $display("FAIL ack_unexpected got a_ack=%0b b_ack=%0b", a_ack, b_ack);
                end else begin
                    ma = exp_ack.pop_front();
                    if ({a_ack, b_ack} !== {!ma.is_b, ma.is_b}) begin
                        miscompares++;
                        $display("FAIL ack_who got a=%0b b=%0b want a=%0b b=%0b",
                                 a_ack, b_ack, !ma.is_b, ma.is_b);
                    end else if (!ma.wr &&
                                 (ma.is_b ? b_rdata : a_rdata) !== ma.rdata) begin
                        miscompares++;
                        $display("FAIL ack_rdata got %h want %h",
                                 ma.is_b ? b_rdata : a_rdata, ma.rdata);
                    end
                end
            end
        end
    end

    // Drops each request on its ack and returns in an IDLE cycle once all expectations drain
    task automatic wait_idle_all(input int budget);
        int n;
        n = 0;
        while ((a_req || b_req || exp_ack.size() != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
        end
        vectors++;
        if (a_req || b_req || exp_ack.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got pending=%0d a_req=%0b b_req=%0b want 0 within %0d cycles",
                     exp_ack.size(), a_req, b_req, budget);
            a_req = 1'b0;
            b_req = 1'b0;
            exp_bus.delete();
            exp_ack.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({a_ack, b_ack, bus_read, bus_write, bus_addr, bus_wdata,
             busy, lock_active, a_rdata, b_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got ack=%b%b strb=%b%b addr=%h wd=%h busy=%b lock=%b rd=%h/%h want all 0",
                     a_ack, b_ack, bus_read, bus_write, bus_addr, bus_wdata,
                     busy, lock_active, a_rdata, b_rdata);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_round_robin();
        push_tx(1'b0, 1'b1, 6'h11, 8'h21);
        push_tx(1'b1, 1'b0, 6'h12, 8'h00);
        drive_a(1'b1, 6'h11, 8'h21);
        drive_b(1'b0, 6'h12, 8'h00);
        wait_idle_all(20);
        push_tx(1'b0, 1'b0, 6'h08, 8'h00);
        push_tx(1'b1, 1'b1, 6'h13, 8'h99);
        drive_a(1'b0, 6'h08, 8'h00);
        drive_b(1'b1, 6'h13, 8'h99);
        wait_idle_all(20);
    endtask

    task automatic test_single_write();
        push_tx(1'b0, 1'b1, 6'h0A, 8'h5A);
        drive_a(1'b1, 6'h0A, 8'h5A);
        @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({bus_write, bus_read, bus_addr, bus_wdata, a_ack} !==
            {1'b1, 1'b0, 6'h0A, 8'h5A, 1'b0}) begin
            miscompares++;
            $display("FAIL write_strobe got wr=%b rd=%b addr=%h wd=%h ack=%b want 1 0 0a 5a 0",
                     bus_write, bus_read, bus_addr, bus_wdata, a_ack);
        end
        @(negedge clk); #1;
        vectors++;
        if ({a_ack, b_ack, bus_write, busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL write_ack got a=%b b=%b wr=%b busy=%b want 1 0 0 1",
                     a_ack, b_ack, bus_write, busy);
        end
        a_req = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_b_read();
        push_tx(1'b1, 1'b0, 6'h08, 8'h00);
        drive_b(1'b0, 6'h08, 8'h00);
        wait_idle_all(10);
        vectors++;
        if (b_rdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL b_read_hold got %h want c3", b_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        push_tx(1'b0, 1'b1, 6'h15, 8'h11);
        drive_a(1'b1, 6'h15, 8'h11);
        n = 0;
        while (!a_ack && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (a_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_ack got %b want 1", a_ack);
        end
        push_tx(1'b0, 1'b0, 6'h16, 8'h22);
        a_wr = 1'b0; a_addr = 6'h16; a_wdata = 8'h22;
        wait_idle_all(10);
        vectors++;
        if (a_rdata !== rd_fn(6'h16)) begin
            miscompares++;
            $display("FAIL b2b_rdata got %h want %h", a_rdata, rd_fn(6'h16));
        end
    endtask

    task automatic test_reset_mid();
        push_tx(1'b0, 1'b1, 6'h20, 8'h77);
        drive_a(1'b1, 6'h20, 8'h77);
        @(posedge clk); #2;
        vectors++;
        if (bus_write !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_issue got bus_write=%b want 1", bus_write);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_read, bus_write, a_ack, b_ack, busy, bus_addr, bus_wdata, a_rdata} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got strb=%b%b ack=%b%b busy=%b addr=%h wd=%h ard=%h want all 0",
                     bus_read, bus_write, a_ack, b_ack, busy, bus_addr, bus_wdata, a_rdata);
        end
        a_req = 1'b0;
        exp_bus.delete();
        exp_ack.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        push_tx(1'b0, 1'b1, 6'h21, 8'h3C);
        push_tx(1'b1, 1'b0, 6'h09, 8'h00);
        drive_a(1'b1, 6'h21, 8'h3C);
        drive_b(1'b0, 6'h09, 8'h00);
        wait_idle_all(20);
    endtask

`ifdef REG_ARB_LOCK16_EN
    task automatic test_lock_pair();
        int n;
        push_tx(1'b0, 1'b1, 6'h03, 8'hA1);
        drive_a(1'b1, 6'h03, 8'hA1);
        @(posedge clk); #1;
        drive_b(1'b1, 6'h30, 8'hB0);
        n = 0;
        while (!a_ack && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        a_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if ({lock_active, busy, b_req} !== 3'b101) begin
            miscompares++;
            $display("FAIL lock_held got lock=%b busy=%b b_req=%b want 1 0 1",
                     lock_active, busy, b_req);
        end
        push_tx(1'b0, 1'b1, 6'h04, 8'hA2);
        push_tx(1'b1, 1'b1, 6'h30, 8'hB0);
        drive_a(1'b1, 6'h04, 8'hA2);
        wait_idle_all(20);
        vectors++;
        if (lock_active !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_release got %b want 0", lock_active);
        end
    endtask

    task automatic test_lock_timeout();
        int n;
        int locked;
        push_tx(1'b0, 1'b1, 6'h00, 8'hC0);
        push_tx(1'b1, 1'b1, 6'h31, 8'hB1);
        drive_a(1'b1, 6'h00, 8'hC0);
        @(posedge clk); #1;
        drive_b(1'b1, 6'h31, 8'hB1);
        n = 0;
        while (!a_ack && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        a_req = 1'b0;
        locked = 0;
        n = 0;
        while (!b_ack && n < 60) begin
            @(negedge clk); #1;
            n++;
            if (lock_active) locked++;
        end
        b_req = 1'b0;
        vectors++;
        if (locked != TO) begin
            miscompares++;
            $display("FAIL lock_timeout got %0d locked idle cycles want %0d", locked, TO);
        end
        @(negedge clk); #1;
    endtask
`else
    task automatic test_no_lock();
        push_tx(1'b0, 1'b1, 6'h03, 8'hA1);
        push_tx(1'b1, 1'b1, 6'h30, 8'hB0);
        drive_a(1'b1, 6'h03, 8'hA1);
        @(posedge clk); #1;
        drive_b(1'b1, 6'h30, 8'hB0);
        wait_idle_all(10);
        vectors++;
        if (lock_active !== 1'b0) begin
            miscompares++;
            $display("FAIL no_lock got lock_active=%b want 0", lock_active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_b_read();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_ARB_LOCK16_EN
        test_lock_pair();
        test_lock_timeout();
`else
        test_no_lock();
`endif
        vectors++;
        if (exp_bus.size() != 0 || exp_ack.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got bus=%0d ack=%0d want 0 0", exp_bus.size(), exp_ack.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
